// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// busy latencies and the raw-code decoder.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Codes above the last listed op behave as OP_NONE.
  function automatic op_e decode_op(input logic [3:0] raw);
    if (raw <= 4'd8) return op_e'(raw);
    return OP_NONE;
  endfunction

endpackage

// File: rtl/mdu_cnt.sv
// Loadable down-counter: busy while nonzero, done pulses in the last busy
// cycle so the owner can commit its result on that edge.
module mdu_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (count != '0)
      count <= count - WIDTH'(1);
  end

  assign busy = (count != '0);
  assign done = (count == WIDTH'(1));

endmodule

// File: rtl/mdu.sv
// HI/LO multiply/divide unit with fixed-latency mult and div.
// Define MDU_DIV_EN to build the divider; otherwise DIV/DIVU act as no-ops.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] MDU_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  op_e              dec_op;
  op_e              op_q;
  logic             accept;
  logic             is_mul;
  logic             is_div;
  logic             load;
  logic             done;
  logic [CNT_W-1:0] load_val;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [31:0]      hi;
  logic [31:0]      lo;
  logic [31:0]      hi_next;
  logic [31:0]      lo_next;
  logic [63:0]      ext_a;
  logic [63:0]      ext_b;
  logic [63:0]      product;

  always_comb begin
    dec_op = decode_op(op);
    accept = start && !busy;
    is_mul = (dec_op == OP_MULT) || (dec_op == OP_MULTU);
`ifdef MDU_DIV_EN
    is_div = (dec_op == OP_DIV) || (dec_op == OP_DIVU);
`else
    is_div = 1'b0;
`endif
    load     = accept && (is_mul || is_div);
    load_val = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
  end

  mdu_cnt #(
    .WIDTH(CNT_W)
  ) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .load_val(load_val),
    .busy    (busy),
    .done    (done)
  );

  // One 64x64 multiplier serves both flavours; sign extension selects MULT.
  always_comb begin
    ext_a   = {{32{(op_q == OP_MULT) && a_q[31]}}, a_q};
    ext_b   = {{32{(op_q == OP_MULT) && b_q[31]}}, b_q};
    product = ext_a * ext_b;
  end

`ifdef MDU_DIV_EN
  logic        neg_a;
  logic        neg_b;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] div_lo;
  logic [31:0] div_hi;

  // Signed division runs on magnitudes through the shared unsigned divider.
  always_comb begin
    neg_a    = (op_q == OP_DIV) && a_q[31];
    neg_b    = (op_q == OP_DIV) && b_q[31];
    dividend = neg_a ? -a_q : a_q;
    divisor  = neg_b ? -b_q : b_q;
    quo      = (divisor != '0) ? dividend / divisor : '0;
    rem      = (divisor != '0) ? dividend % divisor : '0;
    div_lo   = (neg_a ^ neg_b) ? -quo : quo;
    div_hi   = neg_a ? -rem : rem;
  end
`endif

  always_comb begin
    hi_next = hi;
    lo_next = lo;
    case (op_q)
      OP_MULT, OP_MULTU: begin
        hi_next = product[63:32];
        lo_next = product[31:0];
      end
`ifdef MDU_DIV_EN
      OP_DIV, OP_DIVU: begin
        if (b_q != '0) begin
          hi_next = div_hi;
          lo_next = div_lo;
        end
      end
`endif
      default: ;
    endcase
  end

  // Accept and done never coincide because done only fires while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi   <= '0;
      lo   <= '0;
      a_q  <= '0;
      b_q  <= '0;
      op_q <= OP_NONE;
    end else begin
      if (accept && dec_op == OP_MTHI) hi <= A;
      if (accept && dec_op == OP_MTLO) lo <= A;
      if (load) begin
        a_q  <= A;
        b_q  <= B;
        op_q <= dec_op;
      end
      if (done) begin
        hi <= hi_next;
        lo <= lo_next;
      end
    end
  end

  always_comb begin
    MDU_out = '0;
    if (dec_op == OP_MFHI)
      MDU_out = hi;
    else if (dec_op == OP_MFLO)
      MDU_out = lo;
  end

endmodule
